framebuffer_swapchain: RTL

Parametrised N-buffered (2 or 3) framebuffer swap chain for the display path. It replaces the fixed double buffer, which swapped blindly every 16 frames. The renderer writes the back buffer through two write ports and declares frames complete with a handshake. VGA and LCD read the front buffer, and buffers rotate only on a vsync falling edge with a completed frame pending.

---
 rtl/fb_pkg.sv | 23 ++
 rtl/framebuffer_bank.sv | 39 +++
 rtl/framebuffer_swapchain.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/fb_pkg.sv
// Shared types, default geometry and the bank-role helper for the framebuffer swap chain.
package fb_pkg;

    localparam int unsigned FB_PIXEL_W = 4;
    localparam int unsigned FB_DEPTH   = 307200;
    localparam int unsigned FB_ADDR_W  = 19;

    typedef logic [1:0] fb_idx_t;

    typedef enum logic {SLOT_EMPTY, SLOT_READY} fb_slot_e;

    typedef enum logic [1:0] {FB_FRONT, FB_BACK, FB_READY, FB_FREE} fb_state_e;

    // With two buffers a finished back buffer doubles as the ready frame.
    function automatic fb_state_e fb_role(input fb_idx_t idx, input fb_idx_t front,
                                          input fb_idx_t back, input fb_slot_e slot,
                                          input bit dual);
        if (idx == front) return FB_FRONT;
        if (idx == back) return (dual && slot == SLOT_READY) ? FB_READY : FB_BACK;
        return (slot == SLOT_READY) ? FB_READY : FB_FREE;
    endfunction

endpackage

// File: rtl/framebuffer_bank.sv
// One true-dual-port pixel RAM: registered reads, out-of-range addresses read 0 and
// never write, and port 2 wins when both ports write the same address.
module framebuffer_bank #(
    parameter int unsigned PIXEL_W = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned ADDR_W  = 4
) (
    input  logic               clk_i,
    input  logic [ADDR_W-1:0]  addr1_i,
    input  logic               we1_i,
    input  logic [PIXEL_W-1:0] wdata1_i,
    output logic [PIXEL_W-1:0] rdata1_o,
    input  logic [ADDR_W-1:0]  addr2_i,
    input  logic               we2_i,
    input  logic [PIXEL_W-1:0] wdata2_i,
    output logic [PIXEL_W-1:0] rdata2_o
);

    localparam int unsigned    MemAw = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] Limit = (ADDR_W + 1)'(DEPTH);

    logic [PIXEL_W-1:0] mem [DEPTH];
    logic               in1, in2;
    logic [MemAw-1:0]   idx1, idx2;

    assign in1  = {1'b0, addr1_i} < Limit;
    assign in2  = {1'b0, addr2_i} < Limit;
    assign idx1 = addr1_i[MemAw-1:0];
    assign idx2 = addr2_i[MemAw-1:0];

    always_ff @(posedge clk_i) begin
        if (we1_i && in1) mem[idx1] <= wdata1_i;
        // Issued last so it overrides port 1 on a same-address collision.
        if (we2_i && in2) mem[idx2] <= wdata2_i;
        rdata1_o <= in1 ? mem[idx1] : '0;
        rdata2_o <= in2 ? mem[idx2] : '0;
    end

endmodule

// File: rtl/framebuffer_swapchain.sv
// Double/triple-buffered framebuffer swap chain with vsync-aligned rotation.
// Define FB_CLEAR_EN to clear each buffer to clear_color as it leaves the display.
module framebuffer_swapchain
    import fb_pkg::*;
#(
    parameter int unsigned PIXEL_W  = FB_PIXEL_W,
    parameter int unsigned DEPTH    = FB_DEPTH,
    parameter int unsigned ADDR_W   = FB_ADDR_W,
    parameter int unsigned NUM_BUFS = 2
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               vsync,
    input  logic [ADDR_W-1:0]  addr_vga,
    output logic [PIXEL_W-1:0] data_vga,
    input  logic [ADDR_W-1:0]  addr_lcd,
    output logic [PIXEL_W-1:0] data_lcd,
    input  logic [ADDR_W-1:0]  addr_wr1,
    input  logic [ADDR_W-1:0]  addr_wr2,
    input  logic [PIXEL_W-1:0] data_wr1,
    input  logic [PIXEL_W-1:0] data_wr2,
    input  logic               wr1_en,
    input  logic               wr2_en,
    output logic               back_ready,
    input  logic               frame_done,
    output logic [1:0]         front_idx,
    output logic               swap_pulse,
`ifdef FB_CLEAR_EN
    input  logic [PIXEL_W-1:0] clear_color,
`endif
    output logic [15:0]        frames_dropped
);

    localparam bit              Dual  = (NUM_BUFS == 2);
    localparam logic [ADDR_W:0] Limit = (ADDR_W + 1)'(DEPTH);

    fb_idx_t    front_q, back_q, spare_q, rd_sel_q;
    fb_slot_e   slot_q;
    logic       back_ready_q, swap_pulse_q, vsync_q, rd_zero_q;
    logic [15:0] dropped_q;

    logic               clr_active;
    fb_idx_t            clr_idx;
    logic [ADDR_W:0]    clr_addr, clr_addr2;
    logic [PIXEL_W-1:0] clr_color;

`ifdef FB_CLEAR_EN
    logic            clr_active_q, clr_last;
    fb_idx_t         clr_idx_q;
    logic [ADDR_W:0] clr_addr_q;

    assign clr_active = clr_active_q;
    assign clr_idx    = clr_idx_q;
    assign clr_addr   = clr_addr_q;
    assign clr_color  = clear_color;
    assign clr_last   = (clr_addr_q + {{(ADDR_W - 1){1'b0}}, 2'b10}) >= Limit;
`else
    assign clr_active = 1'b0;
    assign clr_idx    = '0;
    assign clr_addr   = '0;
    assign clr_color  = '0;
`endif

    assign clr_addr2 = clr_addr + {{ADDR_W{1'b0}}, 1'b1};

    logic vsync_fall, do_swap, do_done;

    assign vsync_fall = vsync_q & ~vsync;
    assign do_swap    = vsync_fall && (slot_q == SLOT_READY) && !clr_active;
    assign do_done    = frame_done && back_ready_q;

    always_ff @(posedge clock) begin
        if (!reset) begin
            front_q      <= 2'd0;
            back_q       <= 2'd1;
            spare_q      <= 2'd2;
            slot_q       <= SLOT_EMPTY;
            back_ready_q <= 1'b1;
            swap_pulse_q <= 1'b0;
            dropped_q    <= '0;
            vsync_q      <= vsync;
            rd_zero_q    <= 1'b1;
            rd_sel_q     <= 2'd0;
`ifdef FB_CLEAR_EN
            clr_active_q <= 1'b0;
            clr_idx_q    <= 2'd0;
            clr_addr_q   <= '0;
`endif
        end else begin
            vsync_q      <= vsync;
            swap_pulse_q <= do_swap;
            rd_zero_q    <= 1'b0;
            rd_sel_q     <= front_q;
            if (Dual) begin
                if (do_swap) begin
                    front_q      <= back_q;
                    back_q       <= front_q;
                    slot_q       <= SLOT_EMPTY;
                    back_ready_q <= 1'b1;
                end else if (do_done) begin
                    slot_q       <= SLOT_READY;
                    back_ready_q <= 1'b0;
                end
            end else begin
                // spare_q holds the ready frame when the slot is full, else the free buffer.
                case ({do_swap, do_done})
                    2'b10: begin
                        front_q <= spare_q;
                        spare_q <= front_q;
                        slot_q  <= SLOT_EMPTY;
                    end
                    2'b01: begin
                        spare_q <= back_q;
                        back_q  <= spare_q;
                        slot_q  <= SLOT_READY;
                        if (slot_q == SLOT_READY && dropped_q != '1) begin
                            dropped_q <= dropped_q + 16'd1;
                        end
                    end
                    2'b11: begin
                        front_q <= spare_q;
                        spare_q <= back_q;
                        back_q  <= front_q;
                        slot_q  <= SLOT_READY;
                    end
                    default: ;
                endcase
            end
`ifdef FB_CLEAR_EN
            if (do_swap) begin
                clr_active_q <= 1'b1;
                clr_idx_q    <= front_q;
                clr_addr_q   <= '0;
                back_ready_q <= 1'b0;
            end else if (clr_active_q) begin
                clr_addr_q <= clr_addr_q + {{(ADDR_W - 1){1'b0}}, 2'b10};
                if (clr_last) begin
                    clr_active_q <= 1'b0;
                    back_ready_q <= 1'b1;
                end
            end
`endif
        end
    end

    logic [ADDR_W-1:0]  b_addr1 [NUM_BUFS];
    logic [ADDR_W-1:0]  b_addr2 [NUM_BUFS];
    logic               b_we1   [NUM_BUFS];
    logic               b_we2   [NUM_BUFS];
    logic [PIXEL_W-1:0] b_wd1   [NUM_BUFS];
    logic [PIXEL_W-1:0] b_wd2   [NUM_BUFS];
    logic [PIXEL_W-1:0] b_rd1   [NUM_BUFS];
    logic [PIXEL_W-1:0] b_rd2   [NUM_BUFS];
    fb_state_e          role    [NUM_BUFS];

    // The front bank's ports serve the displays; other banks take writer or clear traffic.
    always_comb begin
        for (int i = 0; i < NUM_BUFS; i++) begin
            role[i]    = fb_role(fb_idx_t'(i), front_q, back_q, slot_q, Dual);
            b_addr1[i] = addr_wr1;
            b_addr2[i] = addr_wr2;
            b_wd1[i]   = data_wr1;
            b_wd2[i]   = data_wr2;
            b_we1[i]   = (role[i] == FB_BACK) && back_ready_q && wr1_en;
            b_we2[i]   = (role[i] == FB_BACK) && back_ready_q && wr2_en;
            if (role[i] == FB_FRONT) begin
                b_addr1[i] = addr_vga;
                b_addr2[i] = addr_lcd;
                b_we1[i]   = 1'b0;
                b_we2[i]   = 1'b0;
            end else if (clr_active && clr_idx == fb_idx_t'(i)) begin
                b_addr1[i] = clr_addr[ADDR_W-1:0];
                b_addr2[i] = clr_addr2[ADDR_W-1:0];
                b_wd1[i]   = clr_color;
                b_wd2[i]   = clr_color;
                b_we1[i]   = 1'b1;
                b_we2[i]   = clr_addr2 < Limit;
            end
        end
    end

    for (genvar g = 0; g < NUM_BUFS; g++) begin : g_bank
        framebuffer_bank #(
            .PIXEL_W (PIXEL_W),
            .DEPTH   (DEPTH),
            .ADDR_W  (ADDR_W)
        ) u_bank (
            .clk_i    (clock),
            .addr1_i  (b_addr1[g]),
            .we1_i    (b_we1[g]),
            .wdata1_i (b_wd1[g]),
            .rdata1_o (b_rd1[g]),
            .addr2_i  (b_addr2[g]),
            .we2_i    (b_we2[g]),
            .wdata2_i (b_wd2[g]),
            .rdata2_o (b_rd2[g])
        );
    end

    always_comb begin
        data_vga = '0;
        data_lcd = '0;
        for (int i = 0; i < NUM_BUFS; i++) begin
            if (!rd_zero_q && rd_sel_q == fb_idx_t'(i)) begin
                data_vga = b_rd1[i];
                data_lcd = b_rd2[i];
            end
        end
    end

    assign back_ready     = back_ready_q;
    assign front_idx      = front_q;
    assign swap_pulse     = swap_pulse_q;
    assign frames_dropped = dropped_q;

endmodule
